// File: rtl/dual_frame_tx_pkg.sv
// Shared definitions for the redundant dual-channel serial bus: frame geometry,
// CRC constants, FSM state encoding and the single-bit CRC-16 update step.
package dual_frame_tx_pkg;

    localparam int          DEF_DATA_W   = 48;
    localparam int          DEF_CRC_W    = 16;
    localparam logic [15:0] DEF_CRC_POLY = 16'h1021;
    localparam logic [15:0] DEF_CRC_INIT = 16'hFFFF;
    localparam int          DEF_GAP_CYC  = 4;

    // start + payload + crc + stop
    localparam int FRAME_BITS = 1 + DEF_DATA_W + DEF_CRC_W + 1;

    // Down-counter width; large enough for the longest phase (payload).
    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CRC   = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    // One serial CRC step, MSB-first, non-reflected.
    function automatic logic [DEF_CRC_W-1:0] crc16_step(
        input logic [DEF_CRC_W-1:0] crc,
        input logic                 bit_in,
        input logic [DEF_CRC_W-1:0] poly
    );
        logic fb;
        fb = crc[DEF_CRC_W-1] ^ bit_in;
        crc16_step = {crc[DEF_CRC_W-2:0], 1'b0} ^ (fb ? poly : {DEF_CRC_W{1'b0}});
    endfunction

endpackage

// File: rtl/dual_frame_tx_crc16.sv
// Serial CRC-16 accumulator: one data bit per enabled cycle, reseeded on init.
// Shared between the transmitter and the per-channel receive checkers.
module crc16_serial
    import dual_frame_tx_pkg::*;
#(
    parameter logic [15:0] POLY = DEF_CRC_POLY,
    parameter logic [15:0] INIT = DEF_CRC_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: seed has priority over a data step.
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, bit_in, POLY);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/dual_frame_tx.sv
// Transmitter for the redundant dual-channel bus. Latches one payload word per
// valid/ready handshake and sends start, payload (MSB first), CRC-16 (MSB first)
// and stop on two lines. Channel 2 may carry a single injected payload-bit error.
// Every output is a flop loaded from the next-state decode, so outputs change on
// the same edge as the state they describe.
module dual_frame_tx
    import dual_frame_tx_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          CRC_W    = DEF_CRC_W,
    parameter logic [15:0] CRC_POLY = DEF_CRC_POLY,
    parameter logic [15:0] CRC_INIT = DEF_CRC_INIT,
    parameter int          GAP_CYC  = DEF_GAP_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              inj_err,
    output logic              data_ready,
    output logic              tx_line1,
    output logic              tx_line2,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LOAD  = CNT_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);

    // FSM and bit counter
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Datapath
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [CRC_W-1:0]  crc_sh_q;
    logic [CRC_W-1:0]  crc_sh_d;
    logic              inj_q;
    logic              inj_d;

    // Registered outputs
    logic line1_q;
    logic line1_d;
    logic line2_q;
    logic line2_d;
    logic busy_q;
    logic busy_d;
    logic done_q;
    logic done_d;
    logic ready_q;
    logic ready_d;

    // CRC engine hookup
    logic              crc_init_s;
    logic              crc_en_s;
    logic              crc_bit_s;
    logic [CRC_W-1:0]  crc_val_s;
    logic              accept_s;
    logic              cnt_last_s;
    logic              line_s;
    logic              inj_flip_s;

    crc16_serial #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clk     (clk),
        .rst     (rst),
        .init    (crc_init_s),
        .en      (crc_en_s),
        .bit_in  (crc_bit_s),
        .crc_out (crc_val_s)
    );

    // A word is taken only while idle and advertising ready.
    assign accept_s   = data_valid && ready_q && (state_q == ST_IDLE);
    assign cnt_last_s = (cnt_q == CNT_ZERO);

    // State register and phase bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter: each phase loads its length-1 and ends at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_START: begin
                if (cnt_last_s) begin
                    state_d = ST_DATA;
                    cnt_d   = DATA_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_last_s) begin
                    state_d = ST_CRC;
                    cnt_d   = CRC_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_CRC: begin
                if (cnt_last_s) begin
                    state_d = ST_STOP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_last_s) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_last_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output and datapath decode: selects the bit that goes on the lines in the
    // upcoming cycle and advances the shift registers / CRC to match.
    always_comb begin
        shreg_d    = shreg_q;
        crc_sh_d   = crc_sh_q;
        inj_d      = inj_q;
        line_s     = 1'b1;
        crc_init_s = 1'b0;
        crc_en_s   = 1'b0;
        crc_bit_s  = shreg_q[DATA_W-1];
        case (state_d)
            ST_START: begin
                line_s = 1'b0;
                if (state_q == ST_IDLE) begin
                    shreg_d    = data_in;
                    inj_d      = inj_err;
                    crc_init_s = 1'b1;
                end else begin
                    shreg_d = shreg_q;
                end
            end
            ST_DATA: begin
                // The bit going on the line is folded into the CRC at the same edge.
                line_s   = shreg_q[DATA_W-1];
                shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
                crc_en_s = 1'b1;
            end
            ST_CRC: begin
                if (state_q == ST_DATA) begin
                    // CRC has absorbed the final payload bit by now.
                    line_s   = crc_val_s[CRC_W-1];
                    crc_sh_d = {crc_val_s[CRC_W-2:0], 1'b0};
                end else begin
                    line_s   = crc_sh_q[CRC_W-1];
                    crc_sh_d = {crc_sh_q[CRC_W-2:0], 1'b0};
                end
            end
            default: begin
                line_s = 1'b1;
            end
        endcase

        // Channel 2 corruption is confined to the last payload bit.
        inj_flip_s = inj_q && (state_d == ST_DATA) && (cnt_d == CNT_ZERO);

        line1_d = line_s;
        line2_d = line_s ^ inj_flip_s;
        busy_d  = (state_d == ST_START) || (state_d == ST_DATA) ||
                  (state_d == ST_CRC)   || (state_d == ST_STOP);
        done_d  = (state_d == ST_STOP);
        ready_d = (state_d == ST_IDLE);
    end

    // Datapath and output registers; lines idle high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q  <= {DATA_W{1'b0}};
            crc_sh_q <= {CRC_W{1'b0}};
            inj_q    <= 1'b0;
            line1_q  <= 1'b1;
            line2_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            crc_sh_q <= crc_sh_d;
            inj_q    <= inj_d;
            line1_q  <= line1_d;
            line2_q  <= line2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign tx_line1   = line1_q;
    assign tx_line2   = line2_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign data_ready = ready_q;

endmodule

// File: tb/tb_dual_frame_tx.sv
// Bench for dual_frame_tx: frames captured off both lines are compared with a
// byte-wise CRC-16/CCITT-FALSE reference and the documented frame layout.
module tb_dual_frame_tx;

    logic        clk;
    logic        rst;
    logic [47:0] data_in;
    logic        data_valid;
    logic        inj_err;
    logic        data_ready;
    logic        tx_line1;
    logic        tx_line2;
    logic        tx_busy;
    logic        tx_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_count = 0;

    logic [65:0] exp_l1[$];
    logic [65:0] exp_l2[$];
    logic [65:0] cap_l1[$];
    logic [65:0] cap_l2[$];
    logic [65:0] cap_dn[$];
    logic [65:0] cap_bz[$];
    int          cap_start[$];

    logic [65:0] m_l1, m_l2, m_dn, m_bz;
    int          m_idx = 0;
    bit          m_on  = 1'b0;

    dual_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .inj_err    (inj_err),
        .data_ready (data_ready),
        .tx_line1   (tx_line1),
        .tx_line2   (tx_line2),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame capture on the falling edge; a reset abandons any partial frame.
    always @(negedge clk) begin
        if (rst) begin
            m_on  = 1'b0;
            m_idx = 0;
        end else begin
            if (tx_done) done_count++;
            if (!m_on && tx_busy) begin
                m_on  = 1'b1;
                m_idx = 0;
                cap_start.push_back(cyc);
            end
            if (m_on) begin
                m_l1[65-m_idx] = tx_line1;
                m_l2[65-m_idx] = tx_line2;
                m_dn[65-m_idx] = tx_done;
                m_bz[65-m_idx] = tx_busy;
                m_idx++;
                if (m_idx == 66) begin
                    cap_l1.push_back(m_l1);
                    cap_l2.push_back(m_l2);
                    cap_dn.push_back(m_dn);
                    cap_bz.push_back(m_bz);
                    m_on = 1'b0;
                end
            end
        end
    end

    // Conventional software CRC-16/CCITT-FALSE, processed a byte at a time.
    function automatic logic [15:0] ref_crc(input logic [47:0] d);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int k = 5; k >= 0; k--) begin
            b = d[k*8 +: 8];
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++) begin
                if (c[15]) c = (c << 1) ^ 16'h1021;
                else       c = c << 1;
            end
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Offer a word and hold it until the handshake completes; returns just after the accept edge.
    task automatic send(input logic [47:0] d, input logic inj);
        int k;
        logic [65:0] f;
        @(posedge clk);
        #1;
        data_in    = d;
        inj_err    = inj;
        data_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!data_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait_timeout", 66'(k >= 400), 66'd0);
        @(posedge clk);
        #1;
        f = {1'b0, d, ref_crc(d), 1'b1};
        exp_l1.push_back(f);
        exp_l2.push_back(inj ? (f ^ (66'd1 << 17)) : f);
    endtask

    task automatic check_frames(input string tag);
        int k;
        k = 0;
        while (cap_l1.size() < exp_l1.size() && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_count"}, 66'(cap_l1.size()), 66'(exp_l1.size()));
        while (exp_l1.size() > 0 && cap_l1.size() > 0) begin
            check({tag, "_line1"}, cap_l1.pop_front(), exp_l1.pop_front());
            check({tag, "_line2"}, cap_l2.pop_front(), exp_l2.pop_front());
            check({tag, "_done"},  cap_dn.pop_front(), 66'd1);
            check({tag, "_busy"},  cap_bz.pop_front(), {66{1'b1}});
        end
        exp_l1.delete(); exp_l2.delete();
        cap_l1.delete(); cap_l2.delete(); cap_dn.delete(); cap_bz.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [47:0] w;
        rst = 1'b1; data_valid = 1'b0; data_in = 48'h0; inj_err = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_line1", 66'(tx_line1), 66'd1);
        check("rst_line2", 66'(tx_line2), 66'd1);
        check("rst_busy",  66'(tx_busy),  66'd0);
        check("rst_done",  66'(tx_done),  66'd0);
        check("rst_ready", 66'(data_ready), 66'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 66'(data_ready), 66'd1);

        // All-zero and single-one payloads
        send(48'h0, 1'b0);     data_valid = 1'b0;
        send(48'h1, 1'b0);     data_valid = 1'b0;
        check_frames("basic");

        // Injected error on channel 2
        send(48'hA5A5_A5A5_A5A5, 1'b1); data_valid = 1'b0;
        check_frames("inject");

        // Randomized payloads and injection
        for (int i = 0; i < 5; i++) begin
            w = {16'($urandom), 32'($urandom)};
            send(w, 1'($urandom_range(0, 1)));
            data_valid = 1'b0;
        end
        check_frames("random");

        // Back-to-back with valid held high
        cap_start.delete();
        for (int i = 0; i < 3; i++) begin
            w = {16'($urandom), 32'($urandom)};
            send(w, 1'b0);
        end
        data_valid = 1'b0;
        check_frames("b2b");
        check("b2b_starts", 66'(cap_start.size()), 66'd3);
        if (cap_start.size() >= 3) begin
            check("b2b_gap_1", 66'(cap_start[1] - cap_start[0]), 66'd71);
            check("b2b_gap_2", 66'(cap_start[2] - cap_start[1]), 66'd71);
        end

        // Reset in the middle of the payload
        d0 = done_count;
        send({16'($urandom), 32'($urandom)}, 1'b0);
        data_valid = 1'b0;
        repeat (21) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_line1", 66'(tx_line1), 66'd1);
        check("midrst_line2", 66'(tx_line2), 66'd1);
        check("midrst_busy",  66'(tx_busy),  66'd0);
        check("midrst_ready", 66'(data_ready), 66'd0);
        void'(exp_l1.pop_back());
        void'(exp_l2.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_release", 66'(data_ready), 66'd1);
        check("midrst_no_done", 66'(done_count - d0), 66'd0);
        check("midrst_no_frame", 66'(cap_l1.size()), 66'd0);
        send(48'h0123_4567_89AB, 1'b0);
        data_valid = 1'b0;
        check_frames("after_rst");

        // Activity on the inputs while busy must not disturb the frame
        send(48'hDEAD_BEEF_0042, 1'b0);
        data_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_not_ready", 66'(data_ready), 66'd0);
        data_valid = 1'b1;
        inj_err    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = {16'($urandom), 32'($urandom)};
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data_in = {16'($urandom), 32'($urandom)};
            @(posedge clk); #1;
        end
        inj_err = 1'b0;
        check_frames("busy_ignore");
        repeat (100) @(negedge clk);
        check("no_extra_frame", 66'(cap_l1.size() + (m_on ? 1 : 0)), 66'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
